reg_file: RTL and testbench

- Architectural register file with per-register rename status. Sits downstream of the reorder buffer's commit port and alongside the decoder.
- Holds the 32 committed register values. For each register it records whether an in-flight instruction will write it and that instruction's ROB slot.
- Answers the decoder's rs1/rs2 queries combinationally. The decoder then reads the value directly or follows the ROB tag.
- Commit writes come from the ROB. Rollback clears all rename state.

---
 rtl/reg_file_pkg.sv | 12 +
 rtl/reg_query_port.sv | 40 ++++
 rtl/reg_file.sv | 80 ++++++++
 tb/tb_reg_file.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared widths and types for the architectural register file.
// Optional same-cycle commit forwarding is enabled with REG_FILE_BYPASS_EN.
package reg_file_pkg;
  localparam int REG_NUM     = 32;
  localparam int REG_POS_WID = 5;
  localparam int DATA_WID    = 32;
  localparam int ROB_POS_WID = 4;

  typedef logic [REG_POS_WID-1:0] reg_pos_t;
  typedef logic [DATA_WID-1:0]    data_t;
  typedef logic [ROB_POS_WID-1:0] rob_pos_t;
endpackage

// File: rtl/reg_query_port.sv
// Combinational register lookup for one decoder source operand.
// With REG_FILE_BYPASS_EN, a matching same-cycle commit is forwarded.
module reg_query_port
  import reg_file_pkg::*;
(
  input  reg_pos_t                pos,
  input  logic [REG_NUM-1:0]      busy_vec,
  input  rob_pos_t [REG_NUM-1:0]  tag_vec,
  input  data_t    [REG_NUM-1:0]  val_vec,
  input  logic                    reg_write,
  input  reg_pos_t                reg_rd,
  input  data_t                   reg_val,
  input  rob_pos_t                commit_rob_pos,
  output logic                    busy,
  output data_t                   val,
  output rob_pos_t                rob_pos
);
  always_comb begin
    busy    = busy_vec[pos];
    val     = val_vec[pos];
    rob_pos = tag_vec[pos];
    if (pos == '0) begin
      busy = 1'b0;
      val  = '0;
    end
`ifdef REG_FILE_BYPASS_EN
    // Only the producer the decoder would wait on may resolve the query.
    else if (reg_write && reg_rd == pos && busy_vec[pos] &&
             tag_vec[pos] == commit_rob_pos) begin
      busy = 1'b0;
      val  = reg_val;
    end
`endif
  end

`ifndef REG_FILE_BYPASS_EN
  logic unused_commit;
  assign unused_commit = ^{reg_write, reg_rd, reg_val, commit_rob_pos};
`endif
endmodule

// File: rtl/reg_file.sv
// Architectural register file with per-register rename (busy/ROB tag) state.
// Build option: REG_FILE_BYPASS_EN forwards same-cycle commits to queries.
module reg_file
  import reg_file_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  input  logic     rollback,
  input  logic     issue,
  input  reg_pos_t issue_rd,
  input  rob_pos_t issue_rob_pos,
  input  logic     reg_write,
  input  reg_pos_t reg_rd,
  input  data_t    reg_val,
  input  rob_pos_t commit_rob_pos,
  input  reg_pos_t rs1_pos,
  output logic     rs1_busy,
  output data_t    rs1_val,
  output rob_pos_t rs1_rob_pos,
  input  reg_pos_t rs2_pos,
  output logic     rs2_busy,
  output data_t    rs2_val,
  output rob_pos_t rs2_rob_pos
);
  logic [REG_NUM-1:0]     busy_q;
  rob_pos_t [REG_NUM-1:0] tag_q;
  data_t    [REG_NUM-1:0] val_q;

  // rdy is a global stall: when low nothing is accepted and state holds.
  // Ordering below makes issue win over commit on busy/tag, and rollback
  // win over both.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      tag_q  <= '0;
      val_q  <= '0;
    end else if (rdy) begin
      if (reg_write && reg_rd != '0) begin
        val_q[reg_rd] <= reg_val;
        if (tag_q[reg_rd] == commit_rob_pos)
          busy_q[reg_rd] <= 1'b0;
      end
      if (rollback) begin
        busy_q <= '0;
      end else if (issue && issue_rd != '0) begin
        busy_q[issue_rd] <= 1'b1;
        tag_q[issue_rd]  <= issue_rob_pos;
      end
    end
  end

  reg_query_port u_rs1 (
    .pos            (rs1_pos),
    .busy_vec       (busy_q),
    .tag_vec        (tag_q),
    .val_vec        (val_q),
    .reg_write      (reg_write),
    .reg_rd         (reg_rd),
    .reg_val        (reg_val),
    .commit_rob_pos (commit_rob_pos),
    .busy           (rs1_busy),
    .val            (rs1_val),
    .rob_pos        (rs1_rob_pos)
  );

  reg_query_port u_rs2 (
    .pos            (rs2_pos),
    .busy_vec       (busy_q),
    .tag_vec        (tag_q),
    .val_vec        (val_q),
    .reg_write      (reg_write),
    .reg_rd         (reg_rd),
    .reg_val        (reg_val),
    .commit_rob_pos (commit_rob_pos),
    .busy           (rs2_busy),
    .val            (rs2_val),
    .rob_pos        (rs2_rob_pos)
  );
endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: rename, commit, rollback, x0 and stall cases.
// Honours REG_FILE_BYPASS_EN for the same-cycle commit query.
module tb_reg_file;
  import reg_file_pkg::*;

  logic     clk = 1'b0;
  logic     rst, rdy, rollback, issue, reg_write;
  reg_pos_t issue_rd, reg_rd, rs1_pos, rs2_pos;
  rob_pos_t issue_rob_pos, commit_rob_pos, rs1_rob_pos, rs2_rob_pos;
  data_t    reg_val, rs1_val, rs2_val;
  logic     rs1_busy, rs2_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .rollback       (rollback),
    .issue          (issue),
    .issue_rd       (issue_rd),
    .issue_rob_pos  (issue_rob_pos),
    .reg_write      (reg_write),
    .reg_rd         (reg_rd),
    .reg_val        (reg_val),
    .commit_rob_pos (commit_rob_pos),
    .rs1_pos        (rs1_pos),
    .rs1_busy       (rs1_busy),
    .rs1_val        (rs1_val),
    .rs1_rob_pos    (rs1_rob_pos),
    .rs2_pos        (rs2_pos),
    .rs2_busy       (rs2_busy),
    .rs2_val        (rs2_val),
    .rs2_rob_pos    (rs2_rob_pos)
  );

  task automatic clear_inputs();
    rollback       = 1'b0;
    issue          = 1'b0;
    issue_rd       = '0;
    issue_rob_pos  = '0;
    reg_write      = 1'b0;
    reg_rd         = '0;
    reg_val        = '0;
    commit_rob_pos = '0;
  endtask

  // Inputs change 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input reg_pos_t rd, input rob_pos_t tag);
    issue         = 1'b1;
    issue_rd      = rd;
    issue_rob_pos = tag;
  endtask

  task automatic drive_commit(input reg_pos_t rd, input rob_pos_t tag, input data_t v);
    reg_write      = 1'b1;
    reg_rd         = rd;
    reg_val        = v;
    commit_rob_pos = tag;
  endtask

  task automatic check_bit(input string name, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", name, obs, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Query the same register on both ports and compare against expectations.
  task automatic check_q(input string name, input reg_pos_t pos, input logic exp_busy,
                         input data_t exp_val, input logic chk_rob, input rob_pos_t exp_rob);
    rs1_pos = pos;
    rs2_pos = pos;
    #1;
    check_bit({name, ".rs1_busy"}, rs1_busy, exp_busy);
    check_word({name, ".rs1_val"}, rs1_val, exp_val);
    check_bit({name, ".rs2_busy"}, rs2_busy, exp_busy);
    check_word({name, ".rs2_val"}, rs2_val, exp_val);
    if (chk_rob) begin
      check_word({name, ".rs1_rob"}, 32'(rs1_rob_pos), 32'(exp_rob));
      check_word({name, ".rs2_rob"}, 32'(rs2_rob_pos), 32'(exp_rob));
    end
  endtask

  initial begin
    clear_inputs();
    rst     = 1'b1;
    rdy     = 1'b1;
    rs1_pos = '0;
    rs2_pos = '0;
    tick();
    tick();
    rst = 1'b0;
    check_q("reset_r5", 5'd5, 1'b0, 32'h0, 1'b1, 4'd0);

    // Rename then matching commit.
    drive_issue(5'd3, 4'd7);
    tick();
    clear_inputs();
    check_q("issue_r3", 5'd3, 1'b1, 32'h0, 1'b1, 4'd7);
    drive_commit(5'd3, 4'd7, 32'hDEADBEEF);
`ifdef REG_FILE_BYPASS_EN
    check_q("commit_cycle_r3", 5'd3, 1'b0, 32'hDEADBEEF, 1'b1, 4'd7);
`else
    check_q("commit_cycle_r3", 5'd3, 1'b1, 32'h0, 1'b1, 4'd7);
`endif
    tick();
    clear_inputs();
    check_q("commit_r3", 5'd3, 1'b0, 32'hDEADBEEF, 1'b1, 4'd7);

    // Older producer commits while a younger one is pending.
    drive_issue(5'd4, 4'd2);
    tick();
    drive_issue(5'd4, 4'd5);
    tick();
    clear_inputs();
    drive_commit(5'd4, 4'd2, 32'h11);
    check_q("stale_cycle_r4", 5'd4, 1'b1, 32'h0, 1'b1, 4'd5);
    tick();
    clear_inputs();
    check_q("stale_r4", 5'd4, 1'b1, 32'h11, 1'b1, 4'd5);

    // Issue and commit to the same rd in one cycle.
    drive_issue(5'd6, 4'd9);
    drive_commit(5'd6, 4'd1, 32'h66);
    tick();
    clear_inputs();
    check_q("same_cycle_r6", 5'd6, 1'b1, 32'h66, 1'b1, 4'd9);

    // Rollback with coincident commit and issue.
    drive_issue(5'd8, 4'd3);
    tick();
    drive_issue(5'd9, 4'd4);
    tick();
    clear_inputs();
    check_q("pre_rb_r9", 5'd9, 1'b1, 32'h0, 1'b1, 4'd4);
    rollback = 1'b1;
    drive_commit(5'd1, 4'd0, 32'h55);
    drive_issue(5'd10, 4'd6);
    tick();
    clear_inputs();
    check_q("rb_r8", 5'd8, 1'b0, 32'h0, 1'b0, 4'd0);
    check_q("rb_r9", 5'd9, 1'b0, 32'h0, 1'b0, 4'd0);
    check_q("rb_r10", 5'd10, 1'b0, 32'h0, 1'b0, 4'd0);
    check_q("rb_r1", 5'd1, 1'b0, 32'h55, 1'b0, 4'd0);
    check_q("rb_r4", 5'd4, 1'b0, 32'h11, 1'b0, 4'd0);
    check_q("rb_r6", 5'd6, 1'b0, 32'h66, 1'b0, 4'd0);

    // x0 stays zero and never busy.
    drive_commit(5'd0, 4'd3, 32'h1234);
    drive_issue(5'd0, 4'd3);
    tick();
    clear_inputs();
    check_q("x0", 5'd0, 1'b0, 32'h0, 1'b0, 4'd0);

    // Stall: nothing changes while rdy is low, queries stay live.
    rdy = 1'b0;
    drive_issue(5'd2, 4'd1);
    drive_commit(5'd5, 4'd0, 32'h77);
    check_q("stall_query_r3", 5'd3, 1'b0, 32'hDEADBEEF, 1'b1, 4'd7);
    tick();
    clear_inputs();
    rdy = 1'b1;
    check_q("stall_r2", 5'd2, 1'b0, 32'h0, 1'b1, 4'd0);
    check_q("stall_r5", 5'd5, 1'b0, 32'h0, 1'b1, 4'd0);

    // Reset overrides a low rdy.
    drive_issue(5'd7, 4'd2);
    tick();
    clear_inputs();
    check_q("pre_rst_r7", 5'd7, 1'b1, 32'h0, 1'b1, 4'd2);
    rst = 1'b1;
    rdy = 1'b0;
    tick();
    rst = 1'b0;
    rdy = 1'b1;
    check_q("rst_r7", 5'd7, 1'b0, 32'h0, 1'b1, 4'd0);
    check_q("rst_r3", 5'd3, 1'b0, 32'h0, 1'b1, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
